// File: rtl/spi_pkt_fifo.sv
// Packet FIFO between regwrap strobes and the SPI status bits: program a length,
// fill exactly that many words, drain them, then re-arm on the next write.
module spi_pkt_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              input_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              output_en,
  output logic [DATA_W-1:0] data_out,
  input  logic              length_input_en,
  input  logic [LEN_W-1:0]  length_in,
  output logic [LEN_W-1:0]  length_out,
  input  logic              clear,
  output logic [LEN_W-1:0]  level,
  output logic              empty,
  output logic              full,
  output logic              read_complete,
  output logic              overflow,
  output logic              underflow,
  output logic              length_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [LEN_W-1:0] DEPTH_L  = LEN_W'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_FULL, S_DRAIN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LEN_W-1:0]   level_q, level_d, length_q, length_d, rd_count_q, rd_count_d;
  logic               overflow_q, overflow_d, underflow_q, underflow_d;
  logic               length_err_q, length_err_d;
  logic               wr_en;
  logic [DATA_W-1:0]  mem [DEPTH];

  // DEPTH need not be a power of two, so wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    length_d     = length_q;
    rd_count_d   = rd_count_q;
    overflow_d   = overflow_q;
    underflow_d  = underflow_q;
    length_err_d = length_err_q;
    wr_en        = 1'b0;
    if (clear) begin
      state_d      = S_IDLE;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      level_d      = '0;
      length_d     = '0;
      rd_count_d   = '0;
      overflow_d   = 1'b0;
      underflow_d  = 1'b0;
      length_err_d = 1'b0;
    end else if (length_input_en) begin
      // Data strobes in the same cycle are ignored whether or not the length is legal.
      if (length_in != '0 && length_in <= DEPTH_L) begin
        length_d   = length_in;
        wr_ptr_d   = '0;
        rd_ptr_d   = '0;
        level_d    = '0;
        rd_count_d = '0;
        state_d    = S_FILL;
      end else begin
        length_err_d = 1'b1;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (input_en)  overflow_d  = 1'b1;
          if (output_en) underflow_d = 1'b1;
        end
        S_FILL: begin
          if (input_en) begin
            wr_en    = 1'b1;
            wr_ptr_d = ptr_inc(wr_ptr_q);
            level_d  = level_q + LEN_W'(1);
            if (level_d == length_q) state_d = S_FULL;
          end
          if (output_en) underflow_d = 1'b1;
        end
        S_FULL: begin
          if (input_en) overflow_d = 1'b1;
          if (output_en) begin
            rd_ptr_d   = ptr_inc(rd_ptr_q);
            level_d    = level_q - LEN_W'(1);
            rd_count_d = LEN_W'(1);
            state_d    = (length_q == LEN_W'(1)) ? S_DONE : S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (input_en) overflow_d = 1'b1;
          if (output_en) begin
            rd_ptr_d   = ptr_inc(rd_ptr_q);
            level_d    = level_q - LEN_W'(1);
            rd_count_d = rd_count_q + LEN_W'(1);
            if (rd_count_d == length_q) state_d = S_DONE;
          end
        end
        S_DONE: begin
          // After a full drain rd_ptr == wr_ptr, so the re-armed packet continues in place.
          if (input_en) begin
            wr_en    = 1'b1;
            wr_ptr_d = ptr_inc(wr_ptr_q);
            level_d  = LEN_W'(1);
            state_d  = (length_q == LEN_W'(1)) ? S_FULL : S_FILL;
          end
          if (output_en) underflow_d = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      length_q     <= '0;
      rd_count_q   <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      length_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      length_q     <= length_d;
      rd_count_q   <= rd_count_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      length_err_q <= length_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= data_in;
  end

  assign data_out      = (level_q != '0) ? mem[rd_ptr_q] : '0;
  assign length_out    = length_q;
  assign level         = level_q;
  assign empty         = (level_q == '0);
  assign full          = (state_q == S_FULL);
  assign read_complete = (state_q == S_DONE);
  assign overflow      = overflow_q;
  assign underflow     = underflow_q;
  assign length_err    = length_err_q;

endmodule

// File: tb/tb_spi_pkt_fifo.sv
// Scoreboard bench for spi_pkt_fifo: a queue-based packet model predicts every
// cycle's outputs; a monitor compares them one cycle-edge later.
module tb_spi_pkt_fifo;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int LEN_W  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset = 1'b1, input_en = 1'b0, output_en = 1'b0;
  logic              length_input_en = 1'b0, clear = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic [LEN_W-1:0]  length_in = '0;
  logic [DATA_W-1:0] data_out;
  logic [LEN_W-1:0]  length_out, level;
  logic              empty, full, read_complete, overflow, underflow, length_err;

  spi_pkt_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .input_en(input_en), .data_in(data_in),
    .output_en(output_en), .data_out(data_out), .length_input_en(length_input_en),
    .length_in(length_in), .length_out(length_out), .clear(clear), .level(level),
    .empty(empty), .full(full), .read_complete(read_complete), .overflow(overflow),
    .underflow(underflow), .length_err(length_err)
  );

  typedef struct {
    logic [DATA_W-1:0] data_out;
    logic [LEN_W-1:0]  level;
    logic [LEN_W-1:0]  length;
    logic empty, full, rc, ovf, unf, lerr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  int   cyc_n  = 0;

  // Behavioural model: packet contents as a queue plus the packet phase.
  typedef enum {M_IDLE, M_FILL, M_FULL, M_DRAIN, M_DONE} mstate_t;
  mstate_t          m_state = M_IDLE;
  logic [DATA_W-1:0] m_q[$];
  int               m_len = 0, m_rdc = 0;
  bit               m_ovf = 0, m_unf = 0, m_lerr = 0;

  task automatic model_step(input bit rst, input bit clr, input bit len_en,
                            input int len_v, input bit in_en,
                            input logic [DATA_W-1:0] d, input bit out_en);
    exp_t e;
    if (rst || clr) begin
      m_state = M_IDLE; m_q.delete(); m_len = 0; m_rdc = 0;
      m_ovf = 0; m_unf = 0; m_lerr = 0;
    end else if (len_en) begin
      if (len_v >= 1 && len_v <= DEPTH) begin
        m_len = len_v; m_q.delete(); m_state = M_FILL;
      end else begin
        m_lerr = 1;
      end
    end else begin
      case (m_state)
        M_IDLE: begin
          if (in_en) m_ovf = 1;
          if (out_en) m_unf = 1;
        end
        M_FILL: begin
          if (in_en) begin
            m_q.push_back(d);
            if (m_q.size() == m_len) m_state = M_FULL;
          end
          if (out_en) m_unf = 1;
        end
        M_FULL: begin
          if (in_en) m_ovf = 1;
          if (out_en) begin
            void'(m_q.pop_front());
            m_rdc = 1;
            m_state = (m_rdc == m_len) ? M_DONE : M_DRAIN;
          end
        end
        M_DRAIN: begin
          if (in_en) m_ovf = 1;
          if (out_en) begin
            void'(m_q.pop_front());
            m_rdc++;
            if (m_rdc == m_len) m_state = M_DONE;
          end
        end
        M_DONE: begin
          if (in_en) begin
            m_q.push_back(d);
            m_state = (m_len == 1) ? M_FULL : M_FILL;
          end
          if (out_en) m_unf = 1;
        end
        default: ;
      endcase
    end
    e.data_out = (m_q.size() > 0) ? m_q[0] : '0;
    e.level    = LEN_W'(m_q.size());
    e.length   = LEN_W'(m_len);
    e.empty    = (m_q.size() == 0);
    e.full     = (m_state == M_FULL);
    e.rc       = (m_state == M_DONE);
    e.ovf      = m_ovf;
    e.unf      = m_unf;
    e.lerr     = m_lerr;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit rst, input bit clr, input bit len_en, input int len_v,
                     input bit in_en, input logic [DATA_W-1:0] d, input bit out_en);
    @(negedge clk);
    reset = rst; clear = clr; length_input_en = len_en; length_in = LEN_W'(len_v);
    input_en = in_en; data_in = d; output_en = out_en;
    model_step(rst, clr, len_en, len_v, in_en, d, out_en);
  endtask

  task automatic do_len(input int n);              cyc(0, 0, 1, n, 0, 0, 0); endtask
  task automatic do_wr(input logic [DATA_W-1:0] d); cyc(0, 0, 0, 0, 1, d, 0); endtask
  task automatic do_rd();                          cyc(0, 0, 0, 0, 0, 0, 1); endtask
  task automatic do_idle();                        cyc(0, 0, 0, 0, 0, 0, 0); endtask
  task automatic do_clr();                         cyc(0, 1, 0, 0, 0, 0, 0); endtask
  task automatic do_rst();                         cyc(1, 0, 0, 0, 0, 0, 0); endtask

  // Monitor: every edge that had stimulus issued has one expected snapshot queued.
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    cyc_n++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (data_out === e.data_out && level === e.level && length_out === e.length &&
          empty === e.empty && full === e.full && read_complete === e.rc &&
          overflow === e.ovf && underflow === e.unf && length_err === e.lerr) begin
        passed++;
        $display("cyc %0d ok: dout=%02h lvl=%0d len=%0d e/f/rc=%0b%0b%0b flags=%0b%0b%0b",
                 cyc_n, data_out, level, length_out, empty, full, read_complete,
                 overflow, underflow, length_err);
      end else begin
        $display("FAIL snapshot cyc %0d: got dout=%02h lvl=%0d len=%0d e/f/rc=%0b%0b%0b ovf/unf/lerr=%0b%0b%0b want dout=%02h lvl=%0d len=%0d e/f/rc=%0b%0b%0b ovf/unf/lerr=%0b%0b%0b",
                 cyc_n, data_out, level, length_out, empty, full, read_complete,
                 overflow, underflow, length_err, e.data_out, e.level, e.length,
                 e.empty, e.full, e.rc, e.ovf, e.unf, e.lerr);
      end
    end
  end

  initial begin
    int r, n;
    do_rst(); do_rst();

    // basic packet
    do_len(3);
    do_wr(8'h01); do_wr(8'h02); do_wr(8'h03);
    do_rd(); do_rd(); do_rd(); do_idle();

    // overflow / underflow, then clear
    do_len(2); do_rd();
    do_wr(8'h11); do_wr(8'h12); do_wr(8'h13);
    do_clr(); do_idle();

    // wrap-around with back-to-back re-arm
    do_len(10);
    for (int i = 0; i < 10; i++) do_wr(DATA_W'(8'hA0 + i));
    for (int i = 0; i < 10; i++) do_rd();
    for (int i = 0; i < 10; i++) do_wr(DATA_W'(8'hB0 + i));
    for (int i = 0; i < 10; i++) do_rd();
    do_idle();

    // length bounds
    do_clr(); do_len(0); do_len(17);
    do_len(16);
    for (int i = 0; i < 16; i++) do_wr(DATA_W'(8'hC0 + i));
    do_wr(8'hEE);
    do_len(1); do_wr(8'h5A); do_rd(); do_idle();

    // mid-operation events
    do_clr(); do_len(4);
    for (int i = 0; i < 4; i++) do_wr(DATA_W'(8'hD0 + i));
    do_rd(); do_rd();
    do_len(4);
    cyc(0, 0, 1, 4, 1, 8'h77, 0);
    cyc(0, 0, 0, 0, 1, 8'h78, 1);
    for (int i = 0; i < 3; i++) do_wr(DATA_W'(8'hE0 + i));
    do_rst(); do_idle();

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 199);
      n = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 20) : $urandom_range(1, 6);
      cyc(r == 0, (r >= 1 && r <= 3), (r >= 4 && r <= 12), n,
          $urandom_range(0, 99) < 50, DATA_W'($urandom), $urandom_range(0, 99) < 40);
    end
    do_idle();

    // let the monitor consume the remaining snapshots, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain: got %0d pending snapshots want 0", exp_q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/spi_pkt_fifo.md
Name: spi_pkt_fifo

Overview:
- Parametrised packet FIFO, next generation of the byte FIFO behind regwrap in the SPI register map.
- Host first programs a packet length, then writes that many words over SPI. The block raises full; the host reads the words back; the block raises read_complete.
- Adds over the previous FIFO: width, depth and length parameters, level reporting, sticky overflow/underflow/length-error flags, a flush strobe, and automatic re-arm for back-to-back packets.
- Sits between regwrap (single-cycle enable strobes) and the tx/rx status bits.

Parameters:
DATA_W, 8, data word width in bits
DEPTH, 16, storage words; must be >= 2
LEN_W, 8, width of length and level fields; requires 2**LEN_W > DEPTH

Ports:
clk  in  1  system clock, all logic rising-edge
reset  in  1  synchronous, active-high reset
input_en  in  1  one-cycle write strobe from regwrap
data_in  in  DATA_W  write data, sampled when input_en=1
output_en  in  1  one-cycle read (pop) strobe from regwrap
data_out  out  DATA_W  head word (first-word-fall-through)
length_input_en  in  1  one-cycle length write strobe
length_in  in  LEN_W  packet length, sampled when length_input_en=1
length_out  out  LEN_W  programmed packet length
clear  in  1  one-cycle flush strobe
level  out  LEN_W  words currently stored
empty  out  1  level==0
full  out  1  packet fully written (state FULL)
read_complete  out  1  packet fully read (state DONE)
overflow  out  1  sticky: write rejected
underflow  out  1  sticky: read rejected
length_err  out  1  sticky: illegal length written

Behaviour:
- Reset values (reset=1 at a clk edge):
  - state IDLE; pointers, level, length_out = 0.
  - full, read_complete, overflow, underflow, length_err = 0.
  - empty = 1; data_out = 0.
  - Reset mid-packet discards all contents; the storage array itself is not cleared.
- States: IDLE, FILL, FULL, DRAIN, DONE. Flags are registered, valid the cycle after the causing strobe.
- Storage and data_out:
  - Circular buffer of DEPTH words; pointers wrap modulo DEPTH.
  - data_out = mem[rd_ptr] combinationally when level>0, else 0.
  - Pop advances rd_ptr; the new head is visible the next cycle.
- Length write, accepted in any state:
  - If 1 <= length_in <= DEPTH: store length, flush pointers and level, go to FILL, clear full and read_complete.
  - Otherwise: set length_err; state, length and contents are unchanged.
- IDLE:
  - input_en sets overflow and is dropped.
  - output_en sets underflow and is dropped.
- FILL:
  - input_en stores the word, wr_ptr+1, level+1.
  - When the accepted write makes level==length, go to FULL next cycle (full=1).
  - output_en sets underflow and is dropped.
- FULL:
  - input_en sets overflow and is dropped.
  - output_en pops, level-1, rd_count=1, go to DRAIN. full deasserts on this transition.
- DRAIN:
  - output_en pops and increments rd_count.
  - When rd_count reaches length, go to DONE (read_complete=1, empty=1).
  - input_en sets overflow and is dropped.
- DONE:
  - read_complete held high.
  - input_en re-arms a new packet with the same length: store the word, level=1, go to FILL, clear read_complete.
  - If length==1, this write goes directly to FULL.
  - output_en sets underflow.
- Simultaneous strobes, priority: reset > clear > length_input_en > input_en/output_en.
  - Lower-priority strobes in the same cycle are ignored with no flag set.
  - input_en together with output_en is handled per state; at most one of them can be legal, and the other sets its flag.
- clear:
  - Flush pointers and level, length_out=0, go to IDLE.
  - Clear full, read_complete, overflow, underflow, length_err.
- Sticky flags clear only on reset or clear.
- level counts stored words; it never exceeds length, so it never exceeds DEPTH.

Test Plan:
- Basic packet: length 3, write 0x01,0x02,0x03.
  - full=1 one cycle after the third write, level=3.
  - Pop 3 times: data_out 0x01,0x02,0x03 in order.
  - read_complete=1 after the third pop; full=0 after the first pop.
- Overflow/underflow, length 2:
  - Pop in FILL -> underflow=1.
  - Write 3 words -> third write dropped, overflow=1, level=2.
  - clear -> all flags 0, state IDLE, length_out=0.
- Wrap-around, DEPTH=16:
  - Length 10: write/read 10 words, then a back-to-back DONE re-arm with 10 more words.
  - Data matches the 0xA0..0xA9 and 0xB0..0xB9 sequences across the pointer wrap; read_complete pulses twice.
- Length bounds:
  - Length 0 -> length_err=1, state IDLE.
  - Length 17 with DEPTH=16 -> length_err=1.
  - Length 16 -> accept 16 words, full=1.
  - Length 1 -> one write gives full, one pop gives read_complete.
- Mid-operation events:
  - Length write while in DRAIN -> level=0, FILL, read_complete=0.
  - length_input_en and input_en in the same cycle -> write dropped, level=0, no overflow.
  - reset asserted in FULL -> all outputs at reset values next cycle.
